// File: rtl/fp_pkg.sv
// Shared definitions for the sequential binary32 multiplier:
// format widths, special-value constants, FSM states, field helpers.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;
    localparam int BIAS   = 127;
    localparam int FP_W   = EXP_W + MANT_W;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] INF  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SPEC = 3'd1,
        S_MULT = 3'd2,
        S_NORM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic f_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-2:0] f_frac(input logic [FP_W-1:0] x);
        return x[MANT_W-2:0];
    endfunction

endpackage

// File: rtl/fp_mult_seq_ctrl_if.sv
// Operand/result handshake bundle of the sequential multiplier.
// The source/consumer side is master, the controller is slave.
interface fp_mult_seq_ctrl_if #(
    parameter int W = fp_pkg::FP_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/mant_shift_add.sv
// Radix-2 shift-add significand multiplier: one partial product per
// cycle, MANT_W cycles after start, {acc, multiplier} holds the product.
module mant_shift_add #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MANT_W-1:0]     a_m,
    input  logic [MANT_W-1:0]     b_m,
    output logic [2*MANT_W-1:0]   p,
    output logic                  done
);
    localparam int CW = $clog2(MANT_W);

    logic [MANT_W-1:0] mcand;
    logic [MANT_W-1:0] mplr;
    logic [MANT_W-1:0] acc;
    logic [MANT_W-1:0] addend;
    logic [MANT_W:0]   sum;
    logic [CW-1:0]     cnt;
    logic              run;

    assign addend = mplr[0] ? mcand : '0;
    assign sum    = {1'b0, acc} + {1'b0, addend};
    assign p      = {acc, mplr};
    assign done   = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start) begin
            mcand <= a_m;
            mplr  <= b_m;
            acc   <= '0;
            cnt   <= CW'(MANT_W - 1);
            run   <= 1'b1;
        end else if (run) begin
            // carry of the add lands in acc MSB, LSB drops into the low half
            {acc, mplr} <= {sum, mplr[MANT_W-1:1]};
            if (cnt == '0)
                run <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/fp_mult_seq_ctrl.sv
// Sequencing controller for the binary32 multiplier: capture, special
// decode, shift-add multiply, normalize/truncate, pack and hand off.
module fp_mult_seq_ctrl #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_mult_seq_ctrl_if.slave bus
);
    import fp_pkg::*;

    localparam int W  = EXP_W + MANT_W;
    localparam int FW = MANT_W - 1;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] NAN_R =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    state_t state, nxt;

    logic                 sa, sb, za, zb, ia, ib, na, nb, spec, s_cap;
    logic [EXP_W-1:0]     ea, eb;
    logic [FW-1:0]        fa, fb;
    logic signed [EW-1:0] e_cap, e, e_n;
    logic [W-1:0]         spec_r, pack, pend, res_q;
    logic                 sign, ov, start, done, carry;
    logic [FW-1:0]        frac_n;
    logic [2*MANT_W-1:0]  p;
    logic                 unused_lo;

    assign sa = bus.a[W-1];
    assign sb = bus.b[W-1];
    assign ea = bus.a[W-2 -: EXP_W];
    assign eb = bus.b[W-2 -: EXP_W];
    assign fa = bus.a[FW-1:0];
    assign fb = bus.b[FW-1:0];
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = &ea;
    assign ib = &eb;
    assign na = ia && (|fa);
    assign nb = ib && (|fb);
    assign spec  = za | zb | ia | ib;
    assign s_cap = sa ^ sb;
    assign e_cap = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

    always_comb begin
        spec_r = {s_cap, {(W-1){1'b0}}};
        if (na | nb | (ia & zb) | (za & ib))
            spec_r = NAN_R;
        else if (ia | ib)
            spec_r = {s_cap, {EXP_W{1'b1}}, {FW{1'b0}}};
    end

    mant_shift_add #(.MANT_W(MANT_W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_m   ({1'b1, fa}),
        .b_m   ({1'b1, fb}),
        .p     (p),
        .done  (done)
    );

    assign carry  = p[2*MANT_W-1];
    assign frac_n = carry ? p[2*MANT_W-2 -: FW] : p[2*MANT_W-3 -: FW];
    assign e_n    = carry ? e + EW'(1) : e;
    // truncated product bits never reach the result
    assign unused_lo = ^p[MANT_W-2:0];

    always_comb begin
        pack = {sign, e_n[EXP_W-1:0], frac_n};
        if (e_n >= E_MAX)
            pack = {sign, {EXP_W{1'b1}}, {FW{1'b0}}};
        else if (e_n[EW-1] || (e_n == '0))
            pack = {sign, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt   = state;
        start = 1'b0;
        unique case (state)
            S_IDLE: if (bus.in_valid) begin
                start = !spec;
                nxt   = spec ? S_SPEC : S_MULT;
            end
            S_SPEC: nxt = S_DONE;
            S_MULT: if (done) nxt = S_NORM;
            S_NORM: nxt = S_DONE;
            S_DONE: if (ov && bus.out_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // DONE spends its first cycle moving pend into res, then raises out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign  <= 1'b0;
            e     <= '0;
            pend  <= '0;
            res_q <= '0;
            ov    <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.in_valid) begin
                sign <= s_cap;
                e    <= e_cap;
                pend <= spec_r;
            end
            if (state == S_NORM)
                pend <= pack;
            if (state == S_DONE) begin
                if (!ov) begin
                    ov    <= 1'b1;
                    res_q <= pend;
                end else if (bus.out_ready) begin
                    ov <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = ov;
    assign bus.res       = res_q;
endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Bench for fp_mult_seq_ctrl: directed vectors plus random normal pairs
// against a cycle-level behavioural model of the handshake and result.
module tb_fp_mult_seq_ctrl;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fp_mult_seq_ctrl_if bus ();

    fp_mult_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rnd = 1'b0;

    bit          m_busy = 1'b0;
    bit          m_ov = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit is_spec(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        logic [47:0] p;
        logic [22:0] f;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0))
            return QNAN;
        if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0))
            return QNAN;
        if (ex == 255 || ey == 255)
            return {s, 8'hFF, 23'h0};
        if (ex == 0 || ey == 0)
            return {s, 31'h0};
        p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
        e = ex + ey - 127;
        if (p[47]) begin
            f = p[46:24];
            e = e + 1;
        end else begin
            f = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, 8'(e), f};
    endfunction

    // model: accept in idle, result after 26 (normal) or 2 (special) edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_cnt  = 0;
        end else if (m_ov) begin
            if (bus.out_ready) begin
                m_ov   = 1'b0;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_ov = 1'b1;
        end else if (bus.in_valid) begin
            m_busy = 1'b1;
            m_res  = ref_mul(bus.a, bus.b);
            m_cnt  = is_spec(bus.a, bus.b) ? 2 : 26;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) check("res_model", bus.res, m_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input int el);
        int lat;
        start_op(x, y);
        wait_result(lat);
        check("latency", 32'(lat), 32'(el));
        check("res", bus.res, er);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        if ($urandom_range(0, 1) != 0)
            e = 8'($urandom_range(100, 154));
        else
            e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        check("pin_1p5x2", ref_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
        check("pin_m2x3", ref_mul(32'hC0000000, 32'h40400000), 32'hC0C00000);
        check("pin_ovf", ref_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
        check("pin_unf", ref_mul(32'h00800000, 32'h00800000), 32'h00000000);
        check("pin_infx0", ref_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);

        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_res", bus.res, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 26);
        do_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 26);
        do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 26);
        do_op(32'h00000000, 32'h40490FDB, 32'h00000000, 2);
        do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 2);
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 2);
        do_op(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 2);
        do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 26);
        do_op(32'h00800000, 32'h00800000, 32'h00000000, 26);
        do_op(32'h00400000, 32'h40000000, 32'h00000000, 2);

        tick();
        bus.out_ready = 1'b0;
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 26);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_res", bus.res, 32'h40400000);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;

        start_op(32'hC0000000, 32'h40400000);
        repeat (5) tick();
        bus.a = 32'h3F800000;
        bus.b = 32'h3F800000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_result(lat);
        check("busy_pulse_lat", 32'(lat), 32'd20);
        check("busy_pulse_res", bus.res, 32'hC0C00000);
        do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 26);

        tick();
        start_op(32'h3FC00000, 32'h40000000);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_res", bus.res, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 26);

        rnd = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            x = rnd_fp();
            y = rnd_fp();
            start_op(x, y);
            wait_result(lat);
            check("rnd_latency", 32'(lat), 32'd26);
        end
        rnd = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
